// File: rtl/address_mem_decoder.sv
// Reverse map for the associative address encoder: local slot -> global address.
// A power-up sweep clears the table, then binds, unbinds and pipelined lookups run.
module address_mem_decoder #(
   parameter int output_width = 3,
   parameter int input_width  = 16
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    bind_valid,
   input  logic [output_width-1:0] bind_local,
   input  logic [input_width-1:0]  bind_global,
   output logic                    bind_ready,
   output logic                    bind_over,
   input  logic                    unbind,
   input  logic [output_width-1:0] unbind_local,
   input  logic                    rd_req,
   input  logic [output_width-1:0] rd_local,
   output logic                    rd_valid,
   output logic [input_width-1:0]  rd_global,
   output logic                    rd_miss,
   output logic                    busy,
   output logic [output_width:0]   bound_count
);

   localparam int depth = 2**output_width;

   typedef enum logic {INIT, READY} state_t;

   state_t                  state;
   logic [output_width-1:0] cnt;
   logic [input_width-1:0]  mem [depth];
   logic [depth-1:0]        used;
   logic                    bind_new;
   logic                    unbind_hit;

   // A same-slot bind wins over the unbind, so the unbind only counts when it hits another used slot.
   always_comb begin
      bind_new   = bind_valid && !used[bind_local];
      unbind_hit = unbind && used[unbind_local] &&
                   !(bind_valid && (bind_local == unbind_local));
   end

   // busy and bind_ready mirror the state and are registered alongside it.
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= INIT;
         cnt         <= '0;
         busy        <= 1'b1;
         bind_ready  <= 1'b0;
         rd_valid    <= 1'b0;
         rd_global   <= '0;
         rd_miss     <= 1'b0;
         bind_over   <= 1'b0;
         bound_count <= '0;
      end else begin
         rd_valid  <= 1'b0;
         bind_over <= 1'b0;
         case (state)
            INIT: begin
               mem[cnt]  <= '0;
               used[cnt] <= 1'b0;
               cnt       <= cnt + 1'b1;
               if (&cnt) begin
                  state      <= READY;
                  busy       <= 1'b0;
                  bind_ready <= 1'b1;
               end
            end
            READY: begin
               // Lookups see the table as it stood before this edge's writes.
               if (rd_req) begin
                  rd_valid  <= 1'b1;
                  rd_global <= used[rd_local] ? mem[rd_local] : '0;
                  rd_miss   <= !used[rd_local];
               end
               if (unbind_hit) begin
                  used[unbind_local] <= 1'b0;
                  mem[unbind_local]  <= '0;
               end
               if (bind_valid) begin
                  used[bind_local] <= 1'b1;
                  mem[bind_local]  <= bind_global;
                  bind_over        <= used[bind_local];
               end
               bound_count <= bound_count + {{output_width{1'b0}}, bind_new}
                                          - {{output_width{1'b0}}, unbind_hit};
            end
            default: state <= INIT;
         endcase
      end
   end

endmodule

// File: tb/tb_address_mem_decoder.sv
// Bench for address_mem_decoder: directed literal checks plus random traffic
// compared every cycle against a slot-array model.
module tb_address_mem_decoder;

   localparam int OW = 3;
   localparam int IW = 16;
   localparam int D  = 2**OW;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          bind_valid = 1'b0;
   logic [OW-1:0] bind_local = '0;
   logic [IW-1:0] bind_global = '0;
   logic          bind_ready;
   logic          bind_over;
   logic          unbind = 1'b0;
   logic [OW-1:0] unbind_local = '0;
   logic          rd_req = 1'b0;
   logic [OW-1:0] rd_local = '0;
   logic          rd_valid;
   logic [IW-1:0] rd_global;
   logic          rd_miss;
   logic          busy;
   logic [OW:0]   bound_count;

   int checks = 0;
   int errors = 0;

   address_mem_decoder #(.output_width(OW), .input_width(IW)) dut (
      .clock(clock), .reset(reset),
      .bind_valid(bind_valid), .bind_local(bind_local), .bind_global(bind_global),
      .bind_ready(bind_ready), .bind_over(bind_over),
      .unbind(unbind), .unbind_local(unbind_local),
      .rd_req(rd_req), .rd_local(rd_local),
      .rd_valid(rd_valid), .rd_global(rd_global), .rd_miss(rd_miss),
      .busy(busy), .bound_count(bound_count)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model state: what each slot holds, which slots are bound, sweep cycles left.
   logic [IW-1:0] m_tab [D];
   logic [D-1:0]  m_used;
   int            init_left;
   logic          e_busy, e_ready, e_over, e_rd_valid, e_rd_miss;
   logic [IW-1:0] e_rd_global;
   logic [OW:0]   e_count;

   initial begin
      forever begin
         @(posedge clock);
         e_over     = 1'b0;
         e_rd_valid = 1'b0;
         if (reset) begin
            init_left   = D;
            m_used      = '0;
            for (int i = 0; i < D; i++) m_tab[i] = '0;
            e_rd_global = '0;
            e_rd_miss   = 1'b0;
         end else if (init_left > 0) begin
            init_left--;
         end else begin
            if (rd_req) begin
               e_rd_valid  = 1'b1;
               e_rd_miss   = !m_used[rd_local];
               e_rd_global = m_used[rd_local] ? m_tab[rd_local] : '0;
            end
            if (unbind && !(bind_valid && bind_local == unbind_local)) begin
               m_used[unbind_local] = 1'b0;
               m_tab[unbind_local]  = '0;
            end
            if (bind_valid) begin
               e_over             = m_used[bind_local];
               m_used[bind_local] = 1'b1;
               m_tab[bind_local]  = bind_global;
            end
         end
         e_busy  = (init_left != 0);
         e_ready = !e_busy;
         e_count = (OW+1)'($countones(m_used));
         @(negedge clock);
         chk("busy", 32'(busy), 32'(e_busy));
         chk("bind_ready", 32'(bind_ready), 32'(e_ready));
         chk("bind_over", 32'(bind_over), 32'(e_over));
         chk("bound_count", 32'(bound_count), 32'(e_count));
         chk("rd_valid", 32'(rd_valid), 32'(e_rd_valid));
         chk("rd_global", 32'(rd_global), 32'(e_rd_global));
         chk("rd_miss", 32'(rd_miss), 32'(e_rd_miss));
      end
   end

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      bind_valid = 1'b0;
      unbind     = 1'b0;
      rd_req     = 1'b0;
   endtask

   task automatic random_traffic(input int n);
      for (int i = 0; i < n; i++) begin
         bind_valid   = ($urandom_range(0, 2) == 0);
         bind_local   = OW'($urandom_range(0, D-1));
         bind_global  = IW'($urandom);
         unbind       = ($urandom_range(0, 3) == 0);
         unbind_local = OW'($urandom_range(0, D-1));
         rd_req       = ($urandom_range(0, 1) == 0);
         rd_local     = OW'($urandom_range(0, D-1));
         cyc();
      end
      idle();
   endtask

   initial begin
      reset = 1'b1;
      cyc();
      reset  = 1'b0;
      rd_req = 1'b1;
      rd_local = 3'd1;
      // The sweep takes exactly D cycles; requests during it are ignored.
      for (int i = 1; i <= D; i++) begin
         cyc();
         chk("init_busy", 32'(busy), 32'(i < D));
         chk("init_rd_valid", 32'(rd_valid), 32'd0);
      end
      chk("ready_after_init", 32'(bind_ready), 32'd1);
      chk("count_after_init", 32'(bound_count), 32'd0);
      idle();

      bind_valid = 1'b1; bind_local = 3'd5; bind_global = 16'hBEEF;
      cyc();
      idle();
      rd_req = 1'b1; rd_local = 3'd5;
      cyc();
      chk("rd5_valid", 32'(rd_valid), 32'd1);
      chk("rd5_global", 32'(rd_global), 32'hBEEF);
      chk("rd5_miss", 32'(rd_miss), 32'd0);
      chk("rd5_count", 32'(bound_count), 32'd1);
      rd_local = 3'd2;
      cyc();
      chk("rd2_valid", 32'(rd_valid), 32'd1);
      chk("rd2_miss", 32'(rd_miss), 32'd1);
      chk("rd2_global", 32'(rd_global), 32'd0);

      bind_valid = 1'b1; bind_local = 3'd3; bind_global = 16'h1234;
      unbind = 1'b1; unbind_local = 3'd3; rd_local = 3'd3;
      cyc();
      chk("rd3_old_miss", 32'(rd_miss), 32'd1);
      chk("rd3_old_global", 32'(rd_global), 32'd0);
      bind_valid = 1'b0; unbind = 1'b0;
      cyc();
      chk("rd3_new_global", 32'(rd_global), 32'h1234);
      chk("rd3_new_miss", 32'(rd_miss), 32'd0);
      chk("count_two", 32'(bound_count), 32'd2);
      idle();

      for (int i = 0; i < D; i++) begin
         bind_valid = 1'b1; bind_local = OW'(i); bind_global = IW'(16'h1000 + i);
         cyc();
      end
      chk("count_full", 32'(bound_count), 32'd8);
      bind_local = 3'd0; bind_global = 16'hAAAA;
      cyc();
      chk("full_rebind_over", 32'(bind_over), 32'd1);
      chk("full_rebind_count", 32'(bound_count), 32'd8);
      idle();
      unbind = 1'b1; unbind_local = 3'd0;
      cyc();
      chk("unbind0_count", 32'(bound_count), 32'd7);
      chk("unbind0_over", 32'(bind_over), 32'd0);
      idle();

      random_traffic(400);

      rd_req = 1'b1; rd_local = 3'd4;
      cyc();
      reset = 1'b1;
      cyc();
      chk("rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd1);
      chk("rst_count", 32'(bound_count), 32'd0);
      reset = 1'b0;
      idle();
      for (int i = 0; i < D; i++) cyc();
      for (int i = 0; i < D; i++) begin
         rd_req = 1'b1; rd_local = OW'(i);
         cyc();
         chk("post_rst_valid", 32'(rd_valid), 32'd1);
         chk("post_rst_miss", 32'(rd_miss), 32'd1);
         chk("post_rst_global", 32'(rd_global), 32'd0);
      end
      idle();

      random_traffic(600);
      cyc();
      @(negedge clock);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
